// File: rtl/pmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : pmem_responder
// Brief    : Line-granular memory endpoint for the cache pmem port, with a
//            page-history DRAM latency model (hit vs. miss latency).
// Revision : 1.0 - initial release
// ============================================================================
module pmem_responder #(
    parameter int LINES_LOG2   = 9,
    parameter int MISS_LATENCY = 50,
    parameter int HIT_LATENCY  = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pmem_address,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [255:0] pmem_wdata,
    output logic [255:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         proto_err
);

    localparam int              c_CW        = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
    localparam logic [c_CW-1:0] c_HIT_LOAD  = c_CW'(HIT_LATENCY - 1);
    localparam logic [c_CW-1:0] c_MISS_LOAD = c_CW'(MISS_LATENCY - 1);
    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(1);
    localparam logic            c_HIT_ONE   = (HIT_LATENCY == 1);
    localparam logic            c_MISS_ONE  = (MISS_LATENCY == 1);
    localparam int              c_DEPTH     = 1 << LINES_LOG2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RESP    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [31:5]       r_addr;
    logic              r_rd;
    logic              r_wr;
    logic [255:0]      r_wdata;
    logic [25:0]       r_last_page;
    logic              r_page_valid;
    logic [255:0]      r_mem [c_DEPTH];

    logic                  w_idle;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_lat_one;
    logic                  w_mismatch;
    logic                  w_go_resp;
    logic                  w_op_wr;
    logic [LINES_LOG2-1:0] w_idx;
    logic [255:0]          w_wd;
    logic                  w_unused;

    assign w_idle    = (r_state == S_IDLE);
    assign w_req     = pmem_read | pmem_write;
    assign w_hit     = r_page_valid && (pmem_address[31:6] == r_last_page);
    assign w_lat_one = w_hit ? c_HIT_ONE : c_MISS_ONE;
    assign w_unused  = ^pmem_address[4:0];

    // A dropped request is a legal early release; only a changed live request is an error.
    assign w_mismatch = w_req && ((pmem_address[31:5] != r_addr) ||
                                  (pmem_read != r_rd) || (pmem_write != r_wr) ||
                                  (r_wr && (pmem_wdata != r_wdata)));

    // A unit latency skips BUSY, so the access then takes its operands straight from the port.
    assign w_go_resp = (w_idle && w_req && w_lat_one) ||
                       ((r_state == S_BUSY) && (r_cnt == c_CNT_LAST));
    assign w_idx     = w_idle ? pmem_address[5 +: LINES_LOG2] : r_addr[5 +: LINES_LOG2];
    assign w_op_wr   = w_idle ? pmem_write : r_wr;
    assign w_wd      = w_idle ? pmem_wdata : r_wdata;

    always_ff @(posedge clk) begin
        if (w_go_resp && w_op_wr) begin
            r_mem[w_idx] <= w_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_wdata      <= '0;
            r_last_page  <= '0;
            r_page_valid <= 1'b0;
            pmem_rdata   <= '0;
            pmem_resp    <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            pmem_resp <= w_go_resp;
            if (w_go_resp && !w_op_wr) begin
                pmem_rdata <= r_mem[w_idx];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr       <= pmem_address[31:5];
                        r_rd         <= pmem_read;
                        r_wr         <= pmem_write;
                        r_wdata      <= pmem_wdata;
                        r_last_page  <= pmem_address[31:6];
                        r_page_valid <= 1'b1;
                        if (pmem_read && pmem_write) begin
                            proto_err <= 1'b1;
                        end
                        if (w_lat_one) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= w_hit ? c_HIT_LOAD : c_MISS_LOAD;
                        end
                    end
                end
                S_BUSY: begin
                    if (w_mismatch) begin
                        proto_err <= 1'b1;
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP:    r_state <= S_RECOVER;
                S_RECOVER: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
